seg7_scan_ctrl: RTL and testbench

- Parametrised, multiplexed 7-segment scan controller for N common-select digits.
- Successor of the fixed 8-digit scanner. Adds:
  - configurable digit count and scan rate
  - hex, raw and leading-zero-blank modes, with per-digit decimal point
  - PWM brightness
  - tear-free double-buffered loads with a pending flag and frame strobe
- Sits between CPU/MMIO display registers and the board's seg/sel pins.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_scan_ctrl_if.sv | 25 ++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7 scan controller: display modes,
// segment bit positions and the hex-to-segment pattern table.
package seg7_pkg;

    typedef enum logic [1:0] {
        MODE_HEX     = 2'd0,
        MODE_RAW     = 2'd1,
        MODE_HEX_LZB = 2'd2,
        MODE_BLANK   = 2'd3
    } mode_e;

    // Segment bit positions in the logical {dp,g,f,e,d,c,b,a} byte
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Logical (1 = lit) g..a patterns, entry i is the glyph for nibble i
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-register side of the scan controller: load strobe, display
// data and the pending / frame status returned to the CPU.
interface seg7_scan_ctrl_if #(
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned BRIGHT_W = 4
);
    logic                  i_load;
    logic [1:0]            i_mode;
    logic [4*N_DIGITS-1:0] i_hex;
    logic [8*N_DIGITS-1:0] i_raw;
    logic [N_DIGITS-1:0]   i_dp;
    logic [BRIGHT_W-1:0]   i_bright;
    logic                  o_pending;
    logic                  o_frame_done;

    modport master (
        output i_load, i_mode, i_hex, i_raw, i_dp, i_bright,
        input  o_pending, o_frame_done
    );

    modport slave (
        input  i_load, i_mode, i_hex, i_raw, i_dp, i_bright,
        output o_pending, o_frame_done
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to logical 7-segment (g..a, 1 = lit) decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Table lookup of the glyph for the current nibble
    always_comb begin
        o_seg = HEX_SEG[i_nibble];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller for N_DIGITS common-select digits
// with double-buffered display data, PWM brightness and several modes.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 8,
    parameter int unsigned DIV_W          = 15,
    parameter int unsigned BRIGHT_W       = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_ctrl_if.slave     bus,
    output logic [7:0]          o_seg,
    output logic [N_DIGITS-1:0] o_sel
);

    localparam int unsigned    IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    typedef struct packed {
        mode_e                 mode;
        logic [4*N_DIGITS-1:0] hex;
        logic [8*N_DIGITS-1:0] raw;
        logic [N_DIGITS-1:0]   dp;
        logic [BRIGHT_W-1:0]   bright;
    } disp_t;

    localparam disp_t DISP_RST = '{mode: MODE_HEX, hex: '0, raw: '0, dp: '0, bright: '1};

    logic [DIV_W-1:0] prescaler;
    logic [IDX_W-1:0] idx;
    logic             tick;
    logic             commit;
    disp_t            shadow;
    disp_t            active;
    disp_t            load_data;
    logic             pending;
    logic             frame_done;

    logic [3:0]          cur_nib;
    logic [7:0]          cur_raw;
    logic                cur_dp;
    logic                lz_acc;
    logic                lz_blank;
    logic [6:0]          hex_seg;
    logic                pwm_on;
    logic                lit;
    logic [7:0]          seg_n;
    logic [N_DIGITS-1:0] sel_n;

    assign tick   = &prescaler;
    assign commit = tick && (idx == LAST_IDX);

    assign load_data = '{
        mode:   mode_e'(bus.i_mode),
        hex:    bus.i_hex,
        raw:    bus.i_raw,
        dp:     bus.i_dp,
        bright: bus.i_bright
    };

    assign bus.o_pending    = pending;
    assign bus.o_frame_done = frame_done;

    // Free-running slot prescaler and digit index with explicit wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= prescaler + DIV_W'(1);
            if (tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Shadow/active double buffer; commit only at the frame wrap so a frame
    // never mixes old and new data. A load coinciding with the commit lands
    // in the shadow while the active copy takes the previous shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= DISP_RST;
            active     <= DISP_RST;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= commit;
            if (commit && pending) begin
                active <= shadow;
            end
            if (bus.i_load) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Select the current digit's data and its leading-zero status; the scan
    // runs from the top digit down so lz_acc covers nibbles k..N_DIGITS-1
    always_comb begin
        cur_nib  = '0;
        cur_raw  = '0;
        cur_dp   = 1'b0;
        lz_acc   = 1'b1;
        lz_blank = 1'b0;
        for (int unsigned k = N_DIGITS; k > 0; k--) begin
            lz_acc = lz_acc & (active.hex[4*(k-1) +: 4] == 4'd0);
            if (idx == IDX_W'(k - 1)) begin
                cur_nib  = active.hex[4*(k-1) +: 4];
                cur_raw  = active.raw[8*(k-1) +: 8];
                cur_dp   = active.dp[k-1];
                lz_blank = lz_acc && (k != 1);
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .i_nibble (cur_nib),
        .o_seg    (hex_seg)
    );

    // Logical segment/select value for the current digit, gated by PWM
    always_comb begin
        pwm_on = (prescaler[DIV_W-1 -: BRIGHT_W] <= active.bright);
        lit    = pwm_on;
        seg_n  = '0;
        sel_n  = '0;
        unique case (active.mode)
            MODE_HEX: begin
                seg_n         = {1'b0, hex_seg};
                seg_n[SEG_DP] = cur_dp;
            end
            MODE_RAW: begin
                seg_n = cur_raw;
            end
            MODE_HEX_LZB: begin
                seg_n         = {1'b0, hex_seg};
                seg_n[SEG_DP] = cur_dp;
                if (lz_blank) begin
                    lit = 1'b0;
                end
            end
            default: begin
                lit = 1'b0;
            end
        endcase
        if (lit) begin
            sel_n = N_DIGITS'(1) << idx;
        end else begin
            seg_n = '0;
        end
    end

    // Output register with pin polarity applied at its input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_seg <= SEG_ACTIVE_LOW ? '1 : '0;
            o_sel <= SEL_ACTIVE_LOW ? '1 : '0;
        end else begin
            o_seg <= SEG_ACTIVE_LOW ? ~seg_n : seg_n;
            o_sel <= SEL_ACTIVE_LOW ? ~sel_n : sel_n;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: a 6-digit instance checked every
// cycle against a frame-level reference model, plus an 8-digit instance
// left at reset data to check scan wrap at index 7.
module tb_seg7_scan_ctrl;

    localparam int unsigned N      = 6;
    localparam int unsigned DW     = 4;
    localparam int unsigned BW     = 2;
    localparam int unsigned SLOT   = 1 << DW;
    localparam int unsigned FRAME  = SLOT * N;
    localparam int unsigned FRAME8 = SLOT * 8;

    typedef struct {
        logic [1:0]     mode;
        logic [4*N-1:0] hex;
        logic [8*N-1:0] raw;
        logic [N-1:0]   dp;
        logic [BW-1:0]  bright;
    } disp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   seg;
    logic [N-1:0] sel;
    logic [7:0]   seg8;
    logic [7:0]   sel8;

    seg7_scan_ctrl_if #(.N_DIGITS(N), .BRIGHT_W(BW)) bus ();
    seg7_scan_ctrl_if #(.N_DIGITS(8), .BRIGHT_W(BW)) bus8 ();

    seg7_scan_ctrl #(.N_DIGITS(N), .DIV_W(DW), .BRIGHT_W(BW)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .o_seg (seg),
        .o_sel (sel)
    );

    seg7_scan_ctrl #(.N_DIGITS(8), .DIV_W(DW), .BRIGHT_W(BW)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus8.slave),
        .o_seg (seg8),
        .o_sel (sel8)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    disp_t       m_sh;
    disp_t       m_act;
    bit          m_pend;
    disp_t       d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
    endtask

    function automatic disp_t reset_disp();
        disp_t r;
        r.mode = 2'd0; r.hex = '0; r.raw = '0; r.dp = '0; r.bright = '1;
        return r;
    endfunction

    // {lit, logical segments} for digit k at slot position p
    function automatic logic [8:0] view(input disp_t v, input int unsigned k, input int unsigned p);
        logic [7:0] s;
        logic [3:0] nib;
        bit         lit;
        nib = v.hex[4*k +: 4];
        lit = (p / (SLOT >> BW)) <= int'(v.bright);
        case (v.mode)
            2'd0: s = {v.dp[k], hex_glyph[nib]};
            2'd1: s = v.raw[8*k +: 8];
            2'd2: begin
                s = {v.dp[k], hex_glyph[nib]};
                if (k != 0 && (v.hex >> (4*k)) == 0) lit = 1'b0;
            end
            default: begin
                s   = 8'h00;
                lit = 1'b0;
            end
        endcase
        if (!lit) s = 8'h00;
        return {lit, s};
    endfunction

    // One clock: drive inputs, advance the model, compare every output
    task automatic step(input bit load, input disp_t v);
        bit           commit;
        int unsigned  k, k8, p;
        logic [8:0]   vw;
        logic [7:0]   exp_seg;
        logic [N-1:0] exp_sel;
        logic [7:0]   exp_sel8;
        bus.i_load   = load;
        bus.i_mode   = v.mode;
        bus.i_hex    = v.hex;
        bus.i_raw    = v.raw;
        bus.i_dp     = v.dp;
        bus.i_bright = v.bright;
        @(posedge clk);
        #1;
        bus.i_load = 1'b0;
        commit = (cyc % FRAME) == FRAME - 1;
        k      = (cyc / SLOT) % N;
        p      = cyc % SLOT;
        vw     = view(m_act, k, p);
        if (commit && m_pend) m_act = m_sh;
        if (load) begin
            m_sh   = v;
            m_pend = 1'b1;
        end else if (commit) begin
            m_pend = 1'b0;
        end
        exp_seg = ~vw[7:0];
        exp_sel = vw[8] ? ~(N'(1) << k) : '1;
        check("seg", seg, exp_seg);
        check("sel", sel, exp_sel);
        check("pending", bus.o_pending, m_pend);
        check("frame_done", bus.o_frame_done, commit);
        k8       = (cyc / SLOT) % 8;
        exp_sel8 = ~(8'(1) << k8);
        check("sel8", sel8, exp_sel8);
        check("seg8", seg8, 8'hC0);
        check("frame_done8", bus8.o_frame_done, (cyc % FRAME8) == FRAME8 - 1);
        cyc++;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, d);
    endtask

    // Advance until the next step's pre-edge cycle sits at frame offset r
    task automatic align(input int unsigned r);
        for (int unsigned i = 0; i < FRAME && (cyc % FRAME) != r; i++) step(1'b0, d);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_seg", seg, 8'hFF);
        check("rst_sel", sel, 6'h3F);
        check("rst_pending", bus.o_pending, 1'b0);
        check("rst_frame_done", bus.o_frame_done, 1'b0);
        check("rst_sel8", sel8, 8'hFF);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        cyc    = 0;
        m_sh   = reset_disp();
        m_act  = reset_disp();
        m_pend = 1'b0;
    endtask

    function automatic disp_t rand_disp();
        disp_t r;
        r.mode   = 2'($urandom_range(0, 3));
        r.hex    = (4*N)'({$urandom, $urandom}) >> (4 * $urandom_range(0, N));
        r.raw    = (8*N)'({$urandom, $urandom});
        r.dp     = N'($urandom);
        r.bright = BW'($urandom);
        return r;
    endfunction

    initial begin
        bus.i_load   = 1'b0;
        bus.i_mode   = '0;
        bus.i_hex    = '0;
        bus.i_raw    = '0;
        bus.i_dp     = '0;
        bus.i_bright = '0;
        bus8.i_load   = 1'b0;
        bus8.i_mode   = '0;
        bus8.i_hex    = '0;
        bus8.i_raw    = '0;
        bus8.i_dp     = '0;
        bus8.i_bright = '0;
        d = reset_disp();
        @(posedge clk);
        #1;
        do_reset();
        run(20);

        // Hex mode with full brightness, then spot the A and 1 glyphs
        d = '{mode: 2'd0, hex: 24'h12345A, raw: '0, dp: '0, bright: 2'd3};
        step(1'b1, d);
        run(2 * FRAME);
        align(5);
        check("digit0_A", seg, 8'h88);
        align(85);
        check("digit5_1", seg, 8'hF9);

        // Two loads mid-frame: only the second reaches the display
        align(30);
        d = '{mode: 2'd0, hex: 24'hABCDEF, raw: '0, dp: 6'h15, bright: 2'd2};
        step(1'b1, d);
        run(10);
        d = '{mode: 2'd0, hex: 24'h987654, raw: '0, dp: 6'h2A, bright: 2'd1};
        step(1'b1, d);
        run(2 * FRAME);

        // Leading-zero blanking
        d = '{mode: 2'd2, hex: 24'h000050, raw: '0, dp: '0, bright: 2'd3};
        step(1'b1, d);
        run(2 * FRAME);
        d = '{mode: 2'd2, hex: 24'h000000, raw: '0, dp: '0, bright: 2'd3};
        step(1'b1, d);
        run(2 * FRAME);

        // Raw mode, dimmest then brightest
        d = '{mode: 2'd1, hex: '0, raw: 48'h0000_0000_0080, dp: '0, bright: 2'd0};
        step(1'b1, d);
        run(2 * FRAME);
        d.bright = 2'd3;
        step(1'b1, d);
        run(2 * FRAME);

        // Load in the very cycle of the commit tick
        d = '{mode: 2'd0, hex: 24'h111111, raw: '0, dp: '0, bright: 2'd3};
        step(1'b1, d);
        align(FRAME - 1);
        d = '{mode: 2'd0, hex: 24'h777777, raw: '0, dp: '1, bright: 2'd3};
        step(1'b1, d);
        run(2 * FRAME + 5);

        // Randomised loads, some pinned to the commit cycle
        for (int unsigned i = 0; i < 60; i++) begin
            d = rand_disp();
            if ($urandom_range(0, 3) == 0) align(FRAME - 1);
            else run($urandom_range(0, 150));
            step(1'b1, d);
        end
        run(2 * FRAME);

        // Reset mid-operation with a load still pending
        d = rand_disp();
        align(40);
        step(1'b1, d);
        run(3);
        do_reset();
        run(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
